int_sq_window_tp1: RTL and testbench

- Feed side of the CDP LRN int8 sum-of-squares path.
- Accepts one signed int8 element per channel over a valid/ready stream and squares it.
- Keeps a 9-tap channel window centred on each channel, zero-padded at both ends of a channel line.
- Drives sq_pd_int8_0..8, len5/len7/len9 and load_din_d/load_din_2d in exactly the timing int_sum_block_tp1 samples; flags when that block's int8_sum is valid.

---
 rtl/int_sq_window_tp1_pkg.sv | 21 ++
 rtl/int_sq_calc.sv | 18 +
 rtl/int_sq_window_tp1.sv | 119 +++++++++++
 tb/tb_int_sq_window_tp1.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_sq_window_tp1_pkg.sv
// Shared widths, FSM encoding and normalz_len codes for the CDP LRN int8
// square-window feed path.
package int_sq_window_tp1_pkg;
  localparam int pINT8_BW = 9;
  localparam int SQ_W     = 2*pINT8_BW-1;
  localparam int HALF     = 4;
  localparam int TAPS     = 2*HALF+1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sq_state_e;

  typedef enum logic [1:0] {
    LEN3 = 2'd0,
    LEN5 = 2'd1,
    LEN7 = 2'd2,
    LEN9 = 2'd3
  } normalz_len_e;
endpackage

// File: rtl/int_sq_calc.sv
// Signed two's-complement squarer. The result is unsigned and needs only
// 2*IN_W-1 bits because the most negative input squares to exactly 2^(2*IN_W-2).
module int_sq_calc #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 2*IN_W-1
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] sq
);
  logic [IN_W-1:0]  mag;
  logic [OUT_W-1:0] mag_w;

  // Negating the most negative value gives 2^(IN_W-1), which is still the
  // correct magnitude when read as unsigned.
  assign mag   = din[IN_W-1] ? (~din + IN_W'(1)) : din;
  assign mag_w = OUT_W'(mag);
  assign sq    = mag_w * mag_w;
endmodule

// File: rtl/int_sq_window_tp1.sv
// Int8 LRN feed: squares one channel per accept, keeps a 9-tap channel window
// centred on each channel and emits snapshots with the int_sum_block_tp1 timing.
module int_sq_window_tp1
  import int_sq_window_tp1_pkg::*;
(
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic [1:0]          reg2dp_normalz_len,
  input  logic                din_vld,
  output logic                din_rdy,
  input  logic [pINT8_BW-1:0] din_pd,
  input  logic                din_last,
  output logic [SQ_W-1:0]     sq_pd_int8_0,
  output logic [SQ_W-1:0]     sq_pd_int8_1,
  output logic [SQ_W-1:0]     sq_pd_int8_2,
  output logic [SQ_W-1:0]     sq_pd_int8_3,
  output logic [SQ_W-1:0]     sq_pd_int8_4,
  output logic [SQ_W-1:0]     sq_pd_int8_5,
  output logic [SQ_W-1:0]     sq_pd_int8_6,
  output logic [SQ_W-1:0]     sq_pd_int8_7,
  output logic [SQ_W-1:0]     sq_pd_int8_8,
  output logic                len5,
  output logic                len7,
  output logic                len9,
  output logic                load_din_d,
  output logic                load_din_2d,
  output logic                sum_vld
);
  sq_state_e                 state, state_nxt;
  logic [TAPS-1:0][SQ_W-1:0] win, win_nxt, snap;
  logic [TAPS-1:0]           shadow, shadow_nxt;
  logic [1:0]                fl_cnt, fl_cnt_nxt;
  logic [SQ_W-1:0]           sq;
  logic                      accept, shift, emit, line_start;
  logic [2:0]                vld_pipe;

  int_sq_calc #(.IN_W(pINT8_BW), .OUT_W(SQ_W)) u_sq (
    .din (din_pd),
    .sq  (sq)
  );

  assign din_rdy = nvdla_core_rstn && (state != FLUSH);
  assign accept  = din_vld && din_rdy;

  always_comb begin
    state_nxt  = state;
    win_nxt    = win;
    shadow_nxt = shadow;
    fl_cnt_nxt = fl_cnt;
    shift      = 1'b0;
    line_start = 1'b0;
    case (state)
      IDLE: if (accept) begin
        line_start         = 1'b1;
        shift              = 1'b1;
        win_nxt            = '0;
        win_nxt[TAPS-1]    = sq;
        shadow_nxt         = {1'b1, {(TAPS-1){1'b0}}};
        state_nxt          = din_last ? FLUSH : RUN;
      end
      RUN: if (accept) begin
        shift      = 1'b1;
        win_nxt    = {sq, win[TAPS-1:1]};
        shadow_nxt = {1'b1, shadow[TAPS-1:1]};
        if (din_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Four zero shifts push the last HALF channels through the centre tap.
        shift      = 1'b1;
        win_nxt    = {{SQ_W{1'b0}}, win[TAPS-1:1]};
        shadow_nxt = {1'b0, shadow[TAPS-1:1]};
        fl_cnt_nxt = fl_cnt + 2'd1;
        if (fl_cnt == 2'd3) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    emit = shift && shadow_nxt[HALF];
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state    <= IDLE;
      win      <= '0;
      shadow   <= '0;
      fl_cnt   <= '0;
      snap     <= '0;
      len5     <= 1'b0;
      len7     <= 1'b0;
      len9     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      state    <= state_nxt;
      win      <= win_nxt;
      shadow   <= shadow_nxt;
      fl_cnt   <= fl_cnt_nxt;
      vld_pipe <= {vld_pipe[1:0], emit};
      if (emit) snap <= win_nxt;
      if (line_start) begin
        len5 <= (reg2dp_normalz_len == LEN5);
        len7 <= (reg2dp_normalz_len == LEN7);
        len9 <= (reg2dp_normalz_len == LEN9);
      end
    end
  end

  assign load_din_d  = vld_pipe[0];
  assign load_din_2d = vld_pipe[1];
  assign sum_vld     = vld_pipe[2];

  assign sq_pd_int8_0 = snap[0];
  assign sq_pd_int8_1 = snap[1];
  assign sq_pd_int8_2 = snap[2];
  assign sq_pd_int8_3 = snap[3];
  assign sq_pd_int8_4 = snap[4];
  assign sq_pd_int8_5 = snap[5];
  assign sq_pd_int8_6 = snap[6];
  assign sq_pd_int8_7 = snap[7];
  assign sq_pd_int8_8 = snap[8];
endmodule

// File: tb/tb_int_sq_window_tp1.sv
// Directed bench for int_sq_window_tp1: window contents, pulse timing,
// length latching, back-to-back lines and mid-line reset.
module tb_int_sq_window_tp1;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  len_code = 2'd0;
  logic        din_vld = 1'b0;
  logic        din_rdy;
  logic [8:0]  din_pd = '0;
  logic        din_last = 1'b0;
  logic [16:0] s0, s1, s2, s3, s4, s5, s6, s7, s8;
  logic        len5, len7, len9, ld, l2, sv;

  int_sq_window_tp1 dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .reg2dp_normalz_len(len_code),
    .din_vld(din_vld), .din_rdy(din_rdy), .din_pd(din_pd), .din_last(din_last),
    .sq_pd_int8_0(s0), .sq_pd_int8_1(s1), .sq_pd_int8_2(s2), .sq_pd_int8_3(s3),
    .sq_pd_int8_4(s4), .sq_pd_int8_5(s5), .sq_pd_int8_6(s6), .sq_pd_int8_7(s7),
    .sq_pd_int8_8(s8), .len5(len5), .len7(len7), .len9(len9),
    .load_din_d(ld), .load_din_2d(l2), .sum_vld(sv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0][16:0] t;
    logic [2:0]       len;
    int               c;
  } win_t;

  logic [8:0][16:0] taps, prev_taps;
  assign taps = {s8, s7, s6, s5, s4, s3, s2, s1, s0};

  int   cyc = 0;
  int   unstable = 0;
  int   n_chk = 0, n_fail = 0;
  int   acc_cyc, last_acc_cyc;
  int   vals [0:31];
  win_t win_q [$];
  int   l2_q [$], sv_q [$];
  win_t mw;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ld === 1'b1) begin
      mw.t = taps; mw.len = {len9, len7, len5}; mw.c = cyc;
      win_q.push_back(mw);
    end
    if (l2 === 1'b1) l2_q.push_back(cyc);
    if (sv === 1'b1) sv_q.push_back(cyc);
    if (rstn && ld !== 1'b1 && taps !== prev_taps) unstable++;
    prev_taps = taps;
  end

  function automatic logic [8:0][16:0] exp_win(int off, int n, int c);
    logic [8:0][16:0] e;
    e = '0;
    for (int k = 0; k < 9; k++)
      if (c+k-4 >= 0 && c+k-4 < n) e[k] = 17'(vals[off+c+k-4] * vals[off+c+k-4]);
    return e;
  endfunction

  function automatic void clear_q();
    win_q.delete(); l2_q.delete(); sv_q.delete();
  endfunction

  task automatic send(int off, int n, int bub, int chg_at, logic [1:0] chg_val, int abort_at);
    int i = 0;
    int guard = 0;
    int tmp;
    bit acc;
    while (i < n && i != abort_at) begin
      @(negedge clk);
      if (i == chg_at) len_code = chg_val;
      if (bub != 0 && $urandom_range(0, 2) == 0) din_vld = 1'b0;
      else begin
        tmp = vals[off+i];
        din_vld = 1'b1; din_pd = tmp[8:0]; din_last = (i == n-1);
      end
      acc = din_vld && din_rdy;
      if (acc && i == 0) acc_cyc = cyc;
      if (acc) last_acc_cyc = cyc;
      @(posedge clk);
      if (acc) i++;
      guard++;
      if (guard > 300) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout accepted=%0d required=%0d", i, n);
        break;
      end
    end
    @(negedge clk);
    din_vld = 1'b0; din_last = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (din_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got=%b exp=0", din_rdy); end
    n_chk++; if ({ld, l2, sv} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {ld, l2, sv}); end
    n_chk++; if (taps !== '0) begin n_fail++; $display("FAIL reset_taps got=%h exp=0", taps); end
    n_chk++; if ({len9, len7, len5} !== 3'b000) begin n_fail++; $display("FAIL reset_len got=%b exp=000", {len9, len7, len5}); end
    rstn = 1'b1;
    @(negedge clk);
    n_chk++; if (din_rdy !== 1'b1) begin n_fail++; $display("FAIL idle_rdy got=%b exp=1", din_rdy); end
  endtask

  task automatic test_single();
    logic [8:0][16:0] e;
    clear_q();
    vals[0] = -3; len_code = 2'd3;
    send(0, 1, 0, -1, 2'd0, -1);
    // send already consumed flush cycle 1's negedge
    n_chk++; if (din_rdy !== 1'b0) begin n_fail++; $display("FAIL single_flush_rdy cyc=1 got=%b exp=0", din_rdy); end
    for (int f = 2; f <= 4; f++) begin
      @(negedge clk);
      n_chk++; if (din_rdy !== 1'b0) begin n_fail++; $display("FAIL single_flush_rdy cyc=%0d got=%b exp=0", f, din_rdy); end
    end
    repeat (6) @(negedge clk);
    e = '0; e[4] = 17'd9;
    n_chk++; if (win_q.size() != 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", win_q.size()); end
    else begin
      n_chk++; if (win_q[0].t !== e) begin n_fail++; $display("FAIL single_win got=%h exp=%h", win_q[0].t, e); end
      n_chk++; if (win_q[0].c != acc_cyc+5) begin n_fail++; $display("FAIL single_ld_time got=%0d exp=%0d", win_q[0].c, acc_cyc+5); end
      n_chk++; if (win_q[0].len !== 3'b100) begin n_fail++; $display("FAIL single_len got=%b exp=100", win_q[0].len); end
    end
    n_chk++; if (l2_q.size() != 1 || l2_q[0] != acc_cyc+6) begin n_fail++; $display("FAIL single_l2_time n=%0d exp_cyc=%0d", l2_q.size(), acc_cyc+6); end
    n_chk++; if (sv_q.size() != 1 || sv_q[0] != acc_cyc+7) begin n_fail++; $display("FAIL single_sum_vld_time n=%0d exp_cyc=%0d", sv_q.size(), acc_cyc+7); end
  endtask

  task automatic test_ten();
    logic [8:0][16:0] e;
    clear_q();
    for (int i = 0; i < 10; i++) vals[i] = i + 1;
    len_code = 2'd2;
    send(0, 10, 0, -1, 2'd0, -1);
    repeat (10) @(negedge clk);
    n_chk++; if (win_q.size() != 10) begin n_fail++; $display("FAIL ten_count got=%0d exp=10", win_q.size()); end
    else begin
      e = '0; e[4] = 17'd1; e[5] = 17'd4; e[6] = 17'd9; e[7] = 17'd16; e[8] = 17'd25;
      n_chk++; if (win_q[0].t !== e) begin n_fail++; $display("FAIL ten_first got=%h exp=%h", win_q[0].t, e); end
      e = '0; e[0] = 17'd36; e[1] = 17'd49; e[2] = 17'd64; e[3] = 17'd81; e[4] = 17'd100;
      n_chk++; if (win_q[9].t !== e) begin n_fail++; $display("FAIL ten_last got=%h exp=%h", win_q[9].t, e); end
      for (int c = 0; c < 10; c++) begin
        n_chk++;
        if (win_q[c].t !== exp_win(0, 10, c) || win_q[c].len !== 3'b010 ||
            (c > 0 && win_q[c].c != win_q[c-1].c + 1)) begin
          n_fail++; $display("FAIL ten_win ch=%0d got=%h len=%b exp=%h len=010", c, win_q[c].t, win_q[c].len, exp_win(0, 10, c));
        end
      end
    end
    n_chk++; if (sv_q.size() != 10) begin n_fail++; $display("FAIL ten_sum_vld_count got=%0d exp=10", sv_q.size()); end
  endtask

  task automatic test_neg256();
    logic [8:0][16:0] e;
    clear_q();
    vals[0] = -256; vals[1] = 255;
    send(0, 2, 0, -1, 2'd0, -1);
    repeat (10) @(negedge clk);
    n_chk++; if (win_q.size() != 2) begin n_fail++; $display("FAIL neg256_count got=%0d exp=2", win_q.size()); end
    else begin
      e = '0; e[4] = 17'h10000; e[5] = 17'd65025;
      n_chk++; if (win_q[0].t !== e) begin n_fail++; $display("FAIL neg256_ch0 got=%h exp=%h", win_q[0].t, e); end
      e = '0; e[3] = 17'h10000; e[4] = 17'd65025;
      n_chk++; if (win_q[1].t !== e) begin n_fail++; $display("FAIL neg256_ch1 got=%h exp=%h", win_q[1].t, e); end
    end
  endtask

  task automatic test_bubbles();
    clear_q();
    for (int i = 0; i < 8; i++) vals[i] = 3*i - 11;
    len_code = 2'd1;
    unstable = 0;
    send(0, 8, 1, -1, 2'd0, -1);
    repeat (10) @(negedge clk);
    n_chk++; if (unstable != 0) begin n_fail++; $display("FAIL bubble_stable changes=%0d exp=0", unstable); end
    n_chk++; if (win_q.size() != 8) begin n_fail++; $display("FAIL bubble_count got=%0d exp=8", win_q.size()); end
    else for (int c = 0; c < 8; c++) begin
      n_chk++;
      if (win_q[c].t !== exp_win(0, 8, c)) begin
        n_fail++; $display("FAIL bubble_win ch=%0d got=%h exp=%h", c, win_q[c].t, exp_win(0, 8, c));
      end
    end
  endtask

  task automatic test_len_change();
    clear_q();
    for (int i = 0; i < 9; i++) vals[i] = i - 4;
    len_code = 2'd3;
    send(0, 6, 0, 3, 2'd1, -1);
    send(6, 3, 0, -1, 2'd0, -1);
    repeat (10) @(negedge clk);
    n_chk++; if (win_q.size() != 9) begin n_fail++; $display("FAIL lenchg_count got=%0d exp=9", win_q.size()); end
    else for (int c = 0; c < 9; c++) begin
      n_chk++;
      if (win_q[c].len !== ((c < 6) ? 3'b100 : 3'b001)) begin
        n_fail++; $display("FAIL lenchg_len ch=%0d got=%b exp=%b", c, win_q[c].len, (c < 6) ? 3'b100 : 3'b001);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a_last;
    clear_q();
    for (int i = 0; i < 7; i++) vals[i] = 20*i - 60;
    len_code = 2'd0;
    send(0, 3, 0, -1, 2'd0, -1);
    a_last = last_acc_cyc;
    send(3, 4, 0, -1, 2'd0, -1);
    repeat (10) @(negedge clk);
    n_chk++; if (acc_cyc != a_last + 5) begin n_fail++; $display("FAIL b2b_restart got=%0d exp=%0d", acc_cyc, a_last + 5); end
    n_chk++; if (win_q.size() != 7 || sv_q.size() != 7 || l2_q.size() != 7) begin
      n_fail++; $display("FAIL b2b_count ld=%0d l2=%0d sv=%0d exp=7", win_q.size(), l2_q.size(), sv_q.size());
    end
    else for (int c = 0; c < 7; c++) begin
      n_chk++;
      if (win_q[c].t !== ((c < 3) ? exp_win(0, 3, c) : exp_win(3, 4, c-3)) || win_q[c].len !== 3'b000 ||
          l2_q[c] != win_q[c].c + 1 || sv_q[c] != win_q[c].c + 2) begin
        n_fail++; $display("FAIL b2b_win ch=%0d got=%h len=%b ld=%0d l2=%0d sv=%0d", c, win_q[c].t, win_q[c].len, win_q[c].c, l2_q[c], sv_q[c]);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [8:0][16:0] e;
    vals[0] = 7; vals[1] = -8; vals[2] = 9; vals[3] = 10; vals[4] = 11; vals[5] = 12;
    vals[8] = 5; vals[9] = -6;
    len_code = 2'd3;
    send(0, 6, 0, -1, 2'd0, 2);
    @(negedge clk);
    rstn = 1'b0; din_vld = 1'b1; din_pd = 9'd9;
    @(negedge clk);
    n_chk++; if (din_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy got=%b exp=0", din_rdy); end
    @(negedge clk);
    rstn = 1'b1; din_vld = 1'b0;
    clear_q();
    repeat (10) @(negedge clk);
    n_chk++; if (win_q.size() != 0 || sv_q.size() != 0) begin n_fail++; $display("FAIL midrst_stale ld=%0d sv=%0d exp=0", win_q.size(), sv_q.size()); end
    send(8, 2, 0, -1, 2'd0, -1);
    repeat (10) @(negedge clk);
    n_chk++; if (win_q.size() != 2) begin n_fail++; $display("FAIL midrst_count got=%0d exp=2", win_q.size()); end
    else begin
      e = '0; e[4] = 17'd25; e[5] = 17'd36;
      n_chk++; if (win_q[0].t !== e) begin n_fail++; $display("FAIL midrst_ch0 got=%h exp=%h", win_q[0].t, e); end
      e = '0; e[3] = 17'd25; e[4] = 17'd36;
      n_chk++; if (win_q[1].t !== e) begin n_fail++; $display("FAIL midrst_ch1 got=%h exp=%h", win_q[1].t, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ten();
    test_neg256();
    test_bubbles();
    test_len_change();
    test_back_to_back();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end
endmodule
